// File: rtl/bin2bcd_scan_feed_if.sv
// Request/result bundle between the measurement source and the BCD feed for the 8-digit scan driver.
// The master drives the request; the slave (converter) returns status, digits and masks.
interface bin2bcd_scan_feed_if #(
  parameter int BIN_W = 27
);
  logic             start;
  logic [BIN_W-1:0] bin;
  logic [2:0]       dot_pos;
  logic             busy;
  logic             done;
  logic [3:0]       dat_1;
  logic [3:0]       dat_2;
  logic [3:0]       dat_3;
  logic [3:0]       dat_4;
  logic [3:0]       dat_5;
  logic [3:0]       dat_6;
  logic [3:0]       dat_7;
  logic [3:0]       dat_8;
  logic [7:0]       dat_en;
  logic [7:0]       dot_en;

  modport master (
    output start, bin, dot_pos,
    input  busy, done, dat_1, dat_2, dat_3, dat_4, dat_5, dat_6, dat_7, dat_8,
           dat_en, dot_en
  );

  modport slave (
    input  start, bin, dot_pos,
    output busy, done, dat_1, dat_2, dat_3, dat_4, dat_5, dat_6, dat_7, dat_8,
           dat_en, dot_en
  );
endinterface

// File: rtl/bin2bcd_scan_feed.sv
// Iterative double-dabble binary-to-BCD converter with leading-zero blanking and dot placement,
// feeding the 8-digit scan driver with outputs that only change on the LOAD edge.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// CONV   | one add-3/shift iteration per clk, BIN_W iterations
// LOAD   | register digits and masks, pulse done, back to IDLE
module bin2bcd_scan_feed #(
  parameter int BIN_W    = 27,
  parameter int MAX_VAL  = 99999999,
  parameter bit BLANK_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  bin2bcd_scan_feed_if.slave bus
);

  localparam int               CNT_W   = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_V   = BIN_W'(MAX_VAL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LOAD
  } state_t;

  state_t           state;
  logic [BIN_W-1:0] shift_q;
  logic [31:0]      acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       dp_q;
  logic             ovf_q;

  logic             busy_q;
  logic             done_q;
  logic [31:0]      dig_q;
  logic [7:0]       en_q;
  logic [7:0]       dot_q;

  logic [31:0]           acc_adj;
  logic [BIN_W+31:0]     cat_shift;
  logic [7:0]            blank_mask;
  logic [7:0]            en_nxt;
  logic [7:0]            dot_nxt;
  logic [31:0]           dig_nxt;
  logic                  seen;

  // Per-nibble add-3; no carry can leave a nibble since 9+3 < 16.
  always_comb begin
    acc_adj = '0;
    for (int n = 0; n < 8; n++) begin
      if (acc_q[4*n +: 4] >= 4'd5) begin
        acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
      end else begin
        acc_adj[4*n +: 4] = acc_q[4*n +: 4];
      end
    end
    cat_shift = {acc_adj, shift_q} << 1;
  end

  // Scan from SEG1 down: once a nonzero digit is seen, everything to its right stays lit.
  always_comb begin
    seen       = 1'b0;
    blank_mask = '0;
    for (int i = 7; i >= 0; i--) begin
      seen          = seen | (acc_q[4*i +: 4] != 4'd0);
      blank_mask[i] = seen | (3'(i) <= dp_q) | (i == 0);
    end
  end

  always_comb begin
    dig_nxt = acc_q;
    en_nxt  = BLANK_EN ? blank_mask : 8'hFF;
    dot_nxt = (dp_q == 3'd0) ? 8'h00 : (8'h01 << dp_q);
    if (ovf_q) begin
      dig_nxt = 32'hEEEE_EEEE;
      en_nxt  = 8'hFF;
      dot_nxt = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dp_q    <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dig_q   <= '0;
      en_q    <= 8'h00;
      dot_q   <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            shift_q <= bus.bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            dp_q    <= bus.dot_pos;
            ovf_q   <= (bus.bin > MAX_V);
            busy_q  <= 1'b1;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          acc_q   <= cat_shift[BIN_W+31:BIN_W];
          shift_q <= cat_shift[BIN_W-1:0];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_IT) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          dig_q  <= dig_nxt;
          en_q   <= en_nxt;
          dot_q  <= dot_nxt;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.dat_1  = dig_q[31:28];
  assign bus.dat_2  = dig_q[27:24];
  assign bus.dat_3  = dig_q[23:20];
  assign bus.dat_4  = dig_q[19:16];
  assign bus.dat_5  = dig_q[15:12];
  assign bus.dat_6  = dig_q[11:8];
  assign bus.dat_7  = dig_q[7:4];
  assign bus.dat_8  = dig_q[3:0];
  assign bus.dat_en = en_q;
  assign bus.dot_en = dot_q;

endmodule

// File: tb/tb_bin2bcd_scan_feed.sv
// Directed bench for bin2bcd_scan_feed: an arithmetic display model checked every cycle,
// plus hand-computed expectations for the documented cases.
module tb_bin2bcd_scan_feed;

  localparam int BIN_W   = 27;
  localparam int MAX_VAL = 99999999;
  localparam int LAT     = BIN_W + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  bin2bcd_scan_feed_if #(.BIN_W(BIN_W)) bus ();

  bin2bcd_scan_feed #(.BIN_W(BIN_W), .MAX_VAL(MAX_VAL), .BLANK_EN(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_digits(input logic [BIN_W-1:0] b);
    int v;
    logic [31:0] r;
    if (int'(b) > MAX_VAL) return 32'hEEEE_EEEE;
    v = int'(b);
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_en(input logic [BIN_W-1:0] b, input logic [2:0] dp);
    int v, msd;
    logic [7:0] r;
    if (int'(b) > MAX_VAL) return 8'hFF;
    v = int'(b);
    msd = 0;
    for (int k = 0; k < 8; k++) begin
      if (v % 10 != 0) msd = k;
      v = v / 10;
    end
    for (int i = 0; i < 8; i++) r[i] = (i <= msd) || (i <= int'(dp));
    return r;
  endfunction

  function automatic logic [7:0] exp_dot(input logic [BIN_W-1:0] b, input logic [2:0] dp);
    if (int'(b) > MAX_VAL || dp == 3'd0) return 8'h00;
    return 8'(1 << int'(dp));
  endfunction

  int          m_left = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_dig  = '0;
  logic [7:0]  m_en   = '0;
  logic [7:0]  m_dot  = '0;
  logic [BIN_W-1:0] m_bin = '0;
  logic [2:0]  m_dp   = '0;

  // Latency-level model: an accepted request completes LAT edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dig  <= '0;
      m_en   <= '0;
      m_dot  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dig  <= exp_digits(m_bin);
          m_en   <= exp_en(m_bin, m_dp);
          m_dot  <= exp_dot(m_bin, m_dp);
        end
      end else if (bus.start) begin
        m_left <= LAT;
        m_busy <= 1'b1;
        m_bin  <= bus.bin;
        m_dp   <= bus.dot_pos;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
      chk("done", {31'd0, bus.done}, {31'd0, m_done});
      chk("digits", {bus.dat_1, bus.dat_2, bus.dat_3, bus.dat_4,
                     bus.dat_5, bus.dat_6, bus.dat_7, bus.dat_8}, m_dig);
      chk("dat_en", {24'd0, bus.dat_en}, {24'd0, m_en});
      chk("dot_en", {24'd0, bus.dot_en}, {24'd0, m_dot});
    end
  end

  function automatic logic [31:0] dut_digits();
    return {bus.dat_1, bus.dat_2, bus.dat_3, bus.dat_4,
            bus.dat_5, bus.dat_6, bus.dat_7, bus.dat_8};
  endfunction

  // Pulse start for one accepting edge and return cycles until done is seen (0 = timeout).
  task automatic run_conv(input logic [BIN_W-1:0] b, input logic [2:0] dp, output int lat);
    @(posedge clk);
    #2;
    bus.start   = 1'b1;
    bus.bin     = b;
    bus.dot_pos = dp;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pin(input string name, input logic [31:0] d, input logic [7:0] en,
                     input logic [7:0] dot);
    chk({name, "_digits"}, dut_digits(), d);
    chk({name, "_dat_en"}, {24'd0, bus.dat_en}, {24'd0, en});
    chk({name, "_dot_en"}, {24'd0, bus.dot_en}, {24'd0, dot});
  endtask

  initial begin
    int lat;
    int dones;
    bus.start   = 1'b0;
    bus.bin     = '0;
    bus.dot_pos = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    pin("reset", 32'h0, 8'h00, 8'h00);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    run_conv(27'd12345, 3'd0, lat);
    chk("lat_12345", lat, LAT);
    pin("t12345", 32'h0001_2345, 8'h1F, 8'h00);

    run_conv(27'd5, 3'd2, lat);
    chk("lat_5", lat, LAT);
    pin("t5", 32'h0000_0005, 8'h07, 8'h04);

    run_conv(27'd0, 3'd0, lat);
    pin("t0", 32'h0, 8'h01, 8'h00);

    run_conv(27'd99999999, 3'd0, lat);
    pin("tmax", 32'h9999_9999, 8'hFF, 8'h00);

    run_conv(27'd100000000, 3'd5, lat);
    chk("lat_ovf", lat, LAT);
    pin("tovf", 32'hEEEE_EEEE, 8'hFF, 8'h00);

    run_conv(27'h7FF_FFFF, 3'd1, lat);
    pin("tovf_top", 32'hEEEE_EEEE, 8'hFF, 8'h00);

    run_conv(27'd42, 3'd7, lat);
    pin("t42", 32'h0000_0042, 8'hFF, 8'h80);

    run_conv(27'd1000, 3'd1, lat);
    pin("t1000", 32'h0000_1000, 8'h0F, 8'h02);

    // start held through busy; a new bin must not disturb the running conversion
    @(posedge clk);
    #2;
    bus.start   = 1'b1;
    bus.bin     = 27'd777;
    bus.dot_pos = 3'd0;
    @(posedge clk);
    #2;
    bus.bin = 27'd123456;
    dones = 0;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("busy_start_dones", dones, 1);
    pin("t777", 32'h0000_0777, 8'h07, 8'h00);
    bus.bin     = 27'd31415926;
    bus.dot_pos = 3'd3;
    @(posedge clk);
    #1;
    chk("back_to_back_busy", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    chk("lat_b2b", lat, LAT);
    pin("tpi", 32'h3141_5926, 8'hFF, 8'h08);

    // reset mid-conversion
    @(posedge clk);
    #2;
    bus.start   = 1'b1;
    bus.bin     = 27'd86420;
    bus.dot_pos = 3'd4;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    pin("rst_mid", 32'h0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("no_done_after_rst", dones, 0);

    run_conv(27'd86420, 3'd4, lat);
    chk("lat_after_rst", lat, LAT);
    pin("t86420", 32'h0008_6420, 8'h1F, 8'h10);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
